// File: rtl/serial_shift_engine.sv
// serial_shift_engine: parametrised full-duplex serial/parallel shift engine.
// One parallel word is loaded through a valid/ready handshake and shifted out
// one bit per shift_en strobe. A word is received on serial_in at the same time.
// Completion raises a one-cycle rx_valid pulse. abort drops the frame silently.
module serial_shift_engine #(
  parameter int   WIDTH      = 8,
  parameter logic MSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [WIDTH-1:0]             tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  input  logic                         shift_en,
  input  logic                         serial_in,
  output logic                         serial_out,
  input  logic                         abort,
  output logic [WIDTH-1:0]             rx_data,
  output logic                         rx_valid,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_shifted;
  logic             load, step, done, clear;

  // Next shift-register value for a strobe, respecting bit order.
  always_comb begin
    sr_shifted = sr;
    if (MSB_FIRST) sr_shifted = {sr[WIDTH-2:0], serial_in};
    else           sr_shifted = {serial_in, sr[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and decoded outputs. Abort outranks a same-edge strobe.
  always_comb begin
    state_nxt  = state;
    tx_ready   = 1'b0;
    busy       = 1'b0;
    serial_out = IDLE_LEVEL;
    load       = 1'b0;
    step       = 1'b0;
    done       = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy       = 1'b1;
        serial_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];
        if (abort) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end else if (shift_en) begin
          step = 1'b1;
          if (bit_count == LAST) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: shift register, bit counter, received word and its valid pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      bit_count <= '0;
    end else begin
      rx_valid <= done;
      if (load) begin
        sr        <= tx_data;
        bit_count <= '0;
      end else if (clear) begin
        bit_count <= '0;
      end else if (step) begin
        sr <= sr_shifted;
        if (done) begin
          rx_data   <= sr_shifted;
          bit_count <= '0;
        end else begin
          bit_count <= bit_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_shift_engine.sv
// tb_serial_shift_engine: directed vectors for an LSB-first and an MSB-first
// instance driven from shared stimulus, with hand-computed expectations.
module tb_serial_shift_engine;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_valid, shift_en, abort;
  logic       lb, si_const;

  logic       l_ready, l_so, l_rxv, l_busy;
  logic [7:0] l_rx;
  logic [3:0] l_bc;
  logic       m_ready, m_so, m_rxv, m_busy;
  logic [7:0] m_rx;
  logic [3:0] m_bc;
  logic       l_si, m_si;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned busy_cycles;

  assign l_si = lb ? l_so : si_const;
  assign m_si = lb ? m_so : si_const;

  always #5 clk = ~clk;

  serial_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(l_ready),
    .shift_en(shift_en), .serial_in(l_si), .serial_out(l_so), .abort(abort),
    .rx_data(l_rx), .rx_valid(l_rxv), .busy(l_busy), .bit_count(l_bc)
  );

  serial_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
    .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(m_ready),
    .shift_en(shift_en), .serial_in(m_si), .serial_out(m_so), .abort(abort),
    .rx_data(m_rx), .rx_valid(m_rxv), .busy(m_busy), .bit_count(m_bc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete frame with continuous strobes; checks bit stream, counter and completion.
  task automatic frame(input string tag, input logic [7:0] d, input logic [7:0] exp_rx);
    logic [7:0] dv;
    dv = d;
    tx_data = d; tx_valid = 1'b1; shift_en = 1'b1; abort = 1'b0;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check({tag, " lsb out"}, l_so, dv[i]);
      check({tag, " msb out"}, m_so, dv[7-i]);
      check({tag, " lsb bc"}, l_bc, i);
      check({tag, " msb bc"}, m_bc, i);
      tick();
    end
    check({tag, " lsb rxv"}, l_rxv, 1);
    check({tag, " msb rxv"}, m_rxv, 1);
    check({tag, " lsb rx"}, l_rx, exp_rx);
    check({tag, " msb rx"}, m_rx, exp_rx);
    check({tag, " lsb ready"}, l_ready, 1);
    check({tag, " msb ready"}, m_ready, 1);
    shift_en = 1'b0;
    tick();
    check({tag, " lsb rxv drop"}, l_rxv, 0);
    check({tag, " msb rxv drop"}, m_rxv, 0);
  endtask

  initial begin
    // 1: reset with random inputs
    rstn = 1'b0; lb = 1'b1; si_const = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'($urandom); tx_valid = 1'($urandom); shift_en = 1'($urandom);
      abort = 1'($urandom); si_const = 1'($urandom); lb = 1'($urandom);
      tick();
      check("rst ready", {l_ready, m_ready}, 2'b11);
      check("rst busy", {l_busy, m_busy}, 2'b00);
      check("rst rxv", {l_rxv, m_rxv}, 2'b00);
      check("rst rx", {l_rx, m_rx}, 16'h0000);
      check("rst bc", {l_bc, m_bc}, 8'h00);
      check("rst out", {l_so, m_so}, 2'b01);
    end
    tx_valid = 1'b0; shift_en = 1'b0; abort = 1'b0; lb = 1'b1; si_const = 1'b0;
    rstn = 1'b1;
    tick();

    // 2: loopback A5
    lb = 1'b1;
    frame("t2", 8'hA5, 8'hA5);

    // 3: serial_in tied high, 3C
    lb = 1'b0; si_const = 1'b1;
    frame("t3", 8'h3C, 8'hFF);

    // 4: strobe every third cycle, loopback 81
    lb = 1'b1;
    tx_data = 8'h81; tx_valid = 1'b1; shift_en = 1'b0;
    tick();
    tx_valid = 1'b0;
    busy_cycles = 0;
    for (int c = 1; c <= 24; c++) begin
      if (l_busy) busy_cycles++;
      check("t4 bc", l_bc, (c - 1) / 3);
      shift_en = (c % 3 == 0);
      tick();
    end
    check("t4 rxv", {l_rxv, m_rxv}, 2'b11);
    check("t4 rx", {l_rx, m_rx}, 16'h8181);
    check("t4 busy off", l_busy, 0);
    check("t4 busy cycles", busy_cycles, 24);
    shift_en = 1'b0;
    tick();

    // 5: abort after 3 strobes, then abort on the final strobe
    frame("t5 pre", 8'hA5, 8'hA5);
    tx_data = 8'h0F; tx_valid = 1'b1; shift_en = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick(); tick(); tick();
    check("t5 bc before abort", l_bc, 3);
    shift_en = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5 ready", {l_ready, m_ready}, 2'b11);
    check("t5 idle out", {l_so, m_so}, 2'b01);
    check("t5 bc", {l_bc, m_bc}, 8'h00);
    check("t5 rxv", {l_rxv, m_rxv}, 2'b00);
    check("t5 rx", {l_rx, m_rx}, 16'hA5A5);
    tick();
    check("t5 rxv later", {l_rxv, m_rxv}, 2'b00);
    tx_data = 8'h0F; tx_valid = 1'b1; shift_en = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("t5 bc final", {l_bc, m_bc}, 8'h77);
    abort = 1'b1;
    tick();
    abort = 1'b0; shift_en = 1'b0;
    check("t5 final rxv", {l_rxv, m_rxv}, 2'b00);
    check("t5 final rx", {l_rx, m_rx}, 16'hA5A5);
    check("t5 final ready", {l_ready, m_ready}, 2'b11);
    check("t5 final bc", {l_bc, m_bc}, 8'h00);
    tick();
    check("t5 final rxv later", {l_rxv, m_rxv}, 2'b00);

    // 6: load while busy, then asynchronous mid-frame reset
    tx_data = 8'h0F; tx_valid = 1'b1; shift_en = 1'b1;
    tick();
    tx_data = 8'h55;
    for (int i = 0; i < 7; i++) begin
      check("t6 busy", {l_busy, m_busy}, 2'b11);
      tick();
    end
    tick();
    check("t6 rxv", {l_rxv, m_rxv}, 2'b11);
    check("t6 rx", {l_rx, m_rx}, 16'h0F0F);
    check("t6 ready", {l_ready, m_ready}, 2'b11);
    tick();
    tx_valid = 1'b0;
    check("t6 reload busy", {l_busy, m_busy}, 2'b11);
    check("t6 reload bc", {l_bc, m_bc}, 8'h00);
    check("t6 reload out", {l_so, m_so}, 2'b10);
    for (int i = 0; i < 5; i++) tick();
    check("t6 bc before rst", {l_bc, m_bc}, 8'h55);
    #2 rstn = 1'b0;
    #1;
    check("t6 async ready", {l_ready, m_ready}, 2'b11);
    check("t6 async busy", {l_busy, m_busy}, 2'b00);
    check("t6 async rxv", {l_rxv, m_rxv}, 2'b00);
    check("t6 async rx", {l_rx, m_rx}, 16'h0000);
    check("t6 async bc", {l_bc, m_bc}, 8'h00);
    check("t6 async out", {l_so, m_so}, 2'b01);
    shift_en = 1'b0;
    #3 rstn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_shift_engine.md
Name: serial_shift_engine

Overview:
- Parametrised full-duplex serial/parallel shift engine. Successor to the fixed 8-bit controller shift register.
- Adds configurable width and bit order, a valid/ready load handshake, a strobe-paced bit counter, frame completion, and abort.
- Sits between the CPU-side register interface and serial peripherals such as controller ports and the expansion port. It transmits one parallel word and receives one word per frame.

Parameters:
- WIDTH, 8: frame length in bits; must be ≥ 2.
- MSB_FIRST, 0: 0 = LSB shifted out/in first; 1 = MSB first.
- IDLE_LEVEL, 1'b0: value driven on serial_out when not in SHIFT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- tx_data  in  WIDTH  word to transmit; captured on handshake.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  engine idle; a frame is accepted when tx_valid && tx_ready at a clk edge.
- shift_en  in  1  bit strobe; one bit is exchanged per edge with shift_en=1 in SHIFT.
- serial_in  in  1  incoming serial bit, sampled on strobe edges.
- serial_out  out  1  outgoing serial bit.
- abort  in  1  terminates the current frame.
- rx_data  out  WIDTH  last completed received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  frame in progress.
- bit_count  out  $clog2(WIDTH+1)  bits exchanged in the current frame.

Behaviour:
- Reset (rstn=0, asynchronous, immediate, including mid-frame):
  - State IDLE; shift register 0; rx_data 0; rx_valid 0; busy 0; bit_count 0.
  - tx_ready 1; serial_out IDLE_LEVEL.
- States:
  - IDLE: tx_ready=1, busy=0.
  - SHIFT: tx_ready=0, busy=1.
  - tx_ready, busy and serial_out are decoded from state and the shift register only.
- IDLE → SHIFT on tx_valid && tx_ready:
  - Shift register ← tx_data; bit_count ← 0.
  - shift_en and abort are ignored in IDLE.
- serial_out in SHIFT:
  - sr[0] when MSB_FIRST=0; sr[WIDTH-1] when MSB_FIRST=1.
  - The first bit is visible the cycle after the handshake edge.
- SHIFT, edge with shift_en=1 and abort=0:
  - MSB_FIRST=0: sr ← {serial_in, sr[WIDTH-1:1]}.
  - MSB_FIRST=1: sr ← {sr[WIDTH-2:0], serial_in}.
  - bit_count increments.
- Completion, strobe edge with bit_count == WIDTH-1:
  - rx_data ← post-shift value; rx_valid=1 for exactly the next cycle.
  - State → IDLE; bit_count ← 0.
- rx_data bit order:
  - MSB_FIRST=0: first received bit lands in rx_data[0].
  - MSB_FIRST=1: first received bit lands in rx_data[WIDTH-1].
- Edges with shift_en=0 hold all state; gaps between strobes are unbounded.
- abort=1 in SHIFT:
  - State → IDLE; bit_count ← 0; no rx_valid; rx_data unchanged.
  - Abort takes priority over a same-edge shift_en, including on the final bit.
- tx_valid while busy is not accepted; the tx_data word is not captured.
- Back-to-back frames: the earliest next handshake is the edge after completion (first IDLE cycle, concurrent with the rx_valid pulse).
- rx_valid is never high for two consecutive cycles.

Test Plan:
1. Reset: assert rstn=0 with random inputs → tx_ready=1, busy=0, rx_valid=0, rx_data=0, bit_count=0, serial_out=IDLE_LEVEL.
2. WIDTH=8, MSB_FIRST=0, serial_in looped to serial_out, tx_data=8'hA5, shift_en=1 continuously:
   - serial_out sequence 1,0,1,0,0,1,0,1.
   - rx_valid pulses one cycle after the 8th strobe edge with rx_data=8'hA5.
   - tx_ready returns to 1 the same cycle.
3. MSB_FIRST=1, tx_data=8'h3C, serial_in tied 1 → serial_out 0,0,1,1,1,1,0,0; rx_data=8'hFF; bit_count steps 0..7.
4. MSB_FIRST=0, shift_en every 3rd cycle, tx_data=8'h81, serial_in looped:
   - bit_count advances only on strobes; busy stays 1 for 24 cycles.
   - rx_data=8'h81.
5. Abort after 3 strobes, with prior rx_data=8'hA5:
   - Next cycle: tx_ready=1, serial_out=IDLE_LEVEL, bit_count=0.
   - No rx_valid; rx_data stays 8'hA5.
   - Abort coincident with the 8th strobe also suppresses rx_valid.
6. Mid-frame reset and busy-time load:
   - tx_valid with tx_data=8'h55 held during a busy frame → not captured until after completion.
   - Async rstn pulse after 5 strobes → outputs at reset values immediately, with no clk edge needed.
